// File: rtl/simon_pkg.sv
// Shared encodings for the Simon game control unit: FSM state codes and
// the mode-LED patterns shown for each game phase.
package simon_pkg;

  // FSM state encoding, kept as fixed codes so the legacy encoding is preserved
  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_INPUT    = 3'd1;
  localparam logic [2:0] ST_PLAYBACK = 3'd2;
  localparam logic [2:0] ST_REPEAT   = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Mode LED patterns per phase
  localparam logic [2:0] LED_MODE_INIT     = 3'b000;
  localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
  localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
  localparam logic [2:0] LED_MODE_DONE     = 3'b111;

endpackage

// File: rtl/simon_round_counter.sv
// Counts completed Simon rounds. full is high when one more completed
// round would reach MEM_DEPTH, i.e. the memory is about to be filled.
// Only instantiated when SIMON_WIN_DETECT_EN is defined.
module simon_round_counter #(
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic full
);

  localparam int unsigned W = $clog2(MEM_DEPTH) + 1;

  logic [W-1:0] count;

  // Round count register: clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign full = (count == W'(MEM_DEPTH - 1));

endmodule

// File: rtl/simon_control.sv
// Simon game control unit: game-phase FSM driving the datapath controls
// and mode LEDs. All control outputs are Mealy (state + status inputs).
// Optional win detection is compiled in with `define SIMON_WIN_DETECT_EN.
module simon_control
  import simon_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       is_legal,
  input  logic       index_lt_count,
  input  logic       input_eq_pattern,
  output logic       w_en,
  output logic       set_level,
  output logic       read_Memory,
  output logic       cnt_count,
  output logic       clr_count,
  output logic       cnt_index,
  output logic       clr_index,
  output logic [2:0] mode_leds,
  output logic       win
);

  logic [2:0] state;
  logic [2:0] state_next;
  logic       round_full;

  // FSM state register; reset lands in INIT so the datapath is re-cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Mealy control output decode
  always_comb begin
    state_next  = state;
    w_en        = 1'b0;
    set_level   = 1'b0;
    read_Memory = 1'b0;
    cnt_count   = 1'b0;
    clr_count   = 1'b0;
    cnt_index   = 1'b0;
    clr_index   = 1'b0;
    mode_leds   = LED_MODE_INIT;
    case (state)
      ST_INIT: begin
        set_level  = 1'b1;
        clr_count  = 1'b1;
        clr_index  = 1'b1;
        state_next = ST_INPUT;
      end
      ST_INPUT: begin
        mode_leds = LED_MODE_INPUT;
        if (is_legal) begin
          w_en       = 1'b1;
          clr_index  = 1'b1;
          state_next = ST_PLAYBACK;
        end
      end
      ST_PLAYBACK: begin
        mode_leds   = LED_MODE_PLAYBACK;
        read_Memory = 1'b1;
        if (index_lt_count) begin
          cnt_index = 1'b1;
        end else begin
          clr_index  = 1'b1;
          state_next = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        mode_leds = LED_MODE_REPEAT;
        if (!input_eq_pattern) begin
          clr_index  = 1'b1;
          state_next = ST_DONE;
        end else if (index_lt_count) begin
          cnt_index = 1'b1;
        end else if (round_full) begin
          // memory is full: the winning round ends the game instead of growing count
          clr_index  = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_count  = 1'b1;
          state_next = ST_INPUT;
        end
      end
      ST_DONE: begin
        mode_leds   = LED_MODE_DONE;
        read_Memory = 1'b1;
        if (index_lt_count) begin
          cnt_index = 1'b1;
        end else begin
          clr_index = 1'b1;
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

`ifdef SIMON_WIN_DETECT_EN
  logic round_clr;
  logic round_inc;
  logic win_set;

  assign round_clr = (state == ST_INIT);
  assign round_inc = (state == ST_REPEAT) && (state_next == ST_INPUT);
  assign win_set   = (state == ST_REPEAT) && input_eq_pattern &&
                     !index_lt_count && round_full;

  simon_round_counter #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_round_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (round_clr),
    .inc   (round_inc),
    .full  (round_full)
  );

  // Win flag: set on the memory-filling round, held until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= 1'b0;
    end else if (win_set) begin
      win <= 1'b1;
    end
  end
`else
  assign round_full = 1'b0;
  assign win        = 1'b0;
`endif

endmodule

// File: tb/tb_simon_control.sv
// Directed self-checking bench for simon_control with MEM_DEPTH=4.
// Expected results follow the build: SIMON_WIN_DETECT_EN selects whether the
// fourth completed round ends in DONE with win set or returns to INPUT.
module tb_simon_control;
  import simon_pkg::*;

`ifdef SIMON_WIN_DETECT_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       is_legal;
  logic       index_lt_count;
  logic       input_eq_pattern;
  logic       w_en;
  logic       set_level;
  logic       read_Memory;
  logic       cnt_count;
  logic       clr_count;
  logic       cnt_index;
  logic       clr_index;
  logic [2:0] mode_leds;
  logic       win;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  simon_control #(
    .MEM_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .is_legal         (is_legal),
    .index_lt_count   (index_lt_count),
    .input_eq_pattern (input_eq_pattern),
    .w_en             (w_en),
    .set_level        (set_level),
    .read_Memory      (read_Memory),
    .cnt_count        (cnt_count),
    .clr_count        (clr_count),
    .cnt_index        (cnt_index),
    .clr_index        (clr_index),
    .mode_leds        (mode_leds),
    .win              (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic last;
    logic ilc;

    rst_n            = 1'b0;
    is_legal         = 1'b0;
    index_lt_count   = 1'b0;
    input_eq_pattern = 1'b0;
    #3;
    // Outputs during reset
    check("rst_set_level", 8'(set_level), 8'd1);
    check("rst_clr_count", 8'(clr_count), 8'd1);
    check("rst_clr_index", 8'(clr_index), 8'd1);
    check("rst_w_en", 8'(w_en), 8'd0);
    check("rst_read", 8'(read_Memory), 8'd0);
    check("rst_cnt_count", 8'(cnt_count), 8'd0);
    check("rst_cnt_index", 8'(cnt_index), 8'd0);
    check("rst_mode", 8'(mode_leds), 8'(LED_MODE_INIT));
    check("rst_win", 8'(win), 8'd0);
    tick();
    check("rst_hold_mode", 8'(mode_leds), 8'(LED_MODE_INIT));
    rst_n = 1'b1;
    settle();
    check("init_set_level", 8'(set_level), 8'd1);
    tick();
    check("init_to_input", 8'(mode_leds), 8'(LED_MODE_INPUT));

    // Illegal patterns are never written
    for (int i = 0; i < 3; i++) begin
      check("illegal_w_en", 8'(w_en), 8'd0);
      check("illegal_clr_index", 8'(clr_index), 8'd0);
      tick();
      check("illegal_stay", 8'(mode_leds), 8'(LED_MODE_INPUT));
    end

    // Rounds 1..4, round r has r entries
    for (int r = 1; r <= 4; r++) begin
      is_legal = 1'b1;
      settle();
      check("in_w_en", 8'(w_en), 8'd1);
      check("in_clr_index", 8'(clr_index), 8'd1);
      check("in_set_level", 8'(set_level), 8'd0);
      tick();
      is_legal = 1'b0;
      check("pb_mode", 8'(mode_leds), 8'(LED_MODE_PLAYBACK));
      check("pb_read", 8'(read_Memory), 8'd1);
      for (int i = 0; i < r - 1; i++) begin
        index_lt_count = 1'b1;
        settle();
        check("pb_cnt_index", 8'(cnt_index), 8'd1);
        check("pb_no_clr", 8'(clr_index), 8'd0);
        tick();
        check("pb_stay", 8'(mode_leds), 8'(LED_MODE_PLAYBACK));
      end
      index_lt_count = 1'b0;
      settle();
      check("pb_last_clr", 8'(clr_index), 8'd1);
      check("pb_last_no_cnt", 8'(cnt_index), 8'd0);
      tick();
      check("rp_mode", 8'(mode_leds), 8'(LED_MODE_REPEAT));
      check("rp_read", 8'(read_Memory), 8'd0);
      input_eq_pattern = 1'b1;
      for (int i = 0; i < r - 1; i++) begin
        index_lt_count = 1'b1;
        settle();
        check("rp_cnt_index", 8'(cnt_index), 8'd1);
        check("rp_no_cnt_count", 8'(cnt_count), 8'd0);
        tick();
        check("rp_stay", 8'(mode_leds), 8'(LED_MODE_REPEAT));
      end
      index_lt_count = 1'b0;
      settle();
      last = WIN_EN && (r == 4);
      check("rp_end_cnt_count", 8'(cnt_count), 8'(!last));
      check("rp_end_clr_index", 8'(clr_index), 8'(last));
      tick();
      input_eq_pattern = 1'b0;
      check("rp_end_mode", 8'(mode_leds), last ? 8'(LED_MODE_DONE) : 8'(LED_MODE_INPUT));
      check("rp_end_win", 8'(win), 8'(last));
    end

    // Async reset between edges, then restart
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mode", 8'(mode_leds), 8'(LED_MODE_INIT));
    check("async_rst_set_level", 8'(set_level), 8'd1);
    check("async_rst_win", 8'(win), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("restart_input", 8'(mode_leds), 8'(LED_MODE_INPUT));

    // One-entry round that fails in REPEAT
    is_legal = 1'b1;
    tick();
    is_legal = 1'b0;
    index_lt_count = 1'b0;
    tick();
    check("fail_rp_mode", 8'(mode_leds), 8'(LED_MODE_REPEAT));
    input_eq_pattern = 1'b0;
    index_lt_count   = 1'b1;
    settle();
    check("fail_clr_index", 8'(clr_index), 8'd1);
    check("fail_no_cnt_index", 8'(cnt_index), 8'd0);
    check("fail_no_cnt_count", 8'(cnt_count), 8'd0);
    tick();
    check("done_mode", 8'(mode_leds), 8'(LED_MODE_DONE));
    check("done_read", 8'(read_Memory), 8'd1);
    check("done_win", 8'(win), 8'd0);

    // DONE replays memory in a loop
    for (int k = 0; k < 4; k++) begin
      ilc = (k % 2 == 0);
      index_lt_count = ilc;
      settle();
      check("done_cnt_index", 8'(cnt_index), 8'(ilc));
      check("done_clr_index", 8'(clr_index), 8'(!ilc));
      check("done_w_en", 8'(w_en), 8'd0);
      tick();
      check("done_stay", 8'(mode_leds), 8'(LED_MODE_DONE));
    end

    // Async reset out of DONE
    #2;
    rst_n = 1'b0;
    #1;
    check("done_rst_mode", 8'(mode_leds), 8'(LED_MODE_INIT));
    check("done_rst_read", 8'(read_Memory), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/simon_control.md
# simon_control

Control unit for the Simon memory game. It drives the control inputs of the Simon datapath: `w_en`, `set_level`, `read_Memory`, `cnt_count`, `clr_count`, `cnt_index` and `clr_index`. It consumes the datapath's status outputs `is_legal`, `index_lt_count` and `input_eq_pattern`. Together the two blocks form the complete game. This block owns the game-phase FSM and the mode LEDs, and it sits directly beside the datapath in the top level.

## Interface
- `MEM_DEPTH`, 64: pattern memory depth in entries; sets the round limit when win detection is compiled in.
- `clk` in 1: user clock (uclk button); all state changes occur on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `is_legal` in 1: current switch pattern is legal for the latched level.
- `index_lt_count` in 1: datapath index < count.
- `input_eq_pattern` in 1: switch pattern equals mem[index].
- `w_en` out 1: write switch pattern to mem[count].
- `set_level` out 1: latch the level switch.
- `read_Memory` out 1: pattern LEDs show mem[index] instead of the switches.
- `cnt_count` / `clr_count` out 1 each: increment / clear count.
- `cnt_index` / `clr_index` out 1 each: increment / clear index.
- `mode_leds` out 3: phase indicator.
- `win` out 1: player filled the memory.

## Operation
- States are INIT, INPUT, PLAYBACK, REPEAT and DONE.
- All control outputs are combinational from state and status inputs (Mealy). The datapath acts on them at the next rising `clk`.
- The datapath's count always holds the index of the most recently stored entry, or the next free slot while in INPUT.
- **INIT**
  - Asserts `set_level`, `clr_count` and `clr_index`.
  - `mode_leds`=3'b000.
  - Next state is INPUT unconditionally.
- **INPUT** (`mode_leds`=3'b001)
  - If `is_legal`=1: assert `w_en` and `clr_index`, then go to PLAYBACK.
  - Otherwise: all outputs 0 and stay in INPUT. An illegal pattern is never written.
- **PLAYBACK** (`mode_leds`=3'b010, `read_Memory`=1)
  - If `index_lt_count`=1: assert `cnt_index` and stay.
  - Otherwise (index==count, the last entry): assert `clr_index` and go to REPEAT.
- **REPEAT** (`mode_leds`=3'b100, `read_Memory`=0)
  - If `input_eq_pattern`=0: assert `clr_index` and go to DONE.
  - Else if `index_lt_count`=1: assert `cnt_index` and stay.
  - Else: assert `cnt_count` and go to INPUT (round complete).
- **DONE** (`mode_leds`=3'b111, `read_Memory`=1)
  - Replays memory in a loop.
  - If `index_lt_count`=1: assert `cnt_index`.
  - Otherwise: assert `clr_index`, wrapping to index 0.
  - DONE is left only by reset.
- At most one of `cnt_x`/`clr_x` is asserted per counter in any state.
- `w_en` is asserted only in INPUT.

## Timing
- Reset (`rst_n`=0, asynchronous) puts the FSM in INIT.
  - Outputs during reset: `set_level`=1, `clr_count`=1, `clr_index`=1; all other control outputs 0.
  - `mode_leds`=3'b000, `win`=0.
- Reset deasserted mid-game: the first rising `clk` executes INIT, so the datapath is cleared and the level relatched before any INPUT.
- Latencies:
  - State transition: 1 clk edge.
  - Output response to a status change: 0 cycles (combinational).
- Round N (N entries stored) takes 1 INPUT edge, N PLAYBACK edges and N REPEAT edges.
- Level changes outside INIT are ignored, because `set_level` is asserted only there.

## Configuration
- **`SIMON_WIN_DETECT_EN` defined:**
  - An internal round counter (width clog2(`MEM_DEPTH`)+1) is cleared in INIT and incremented on each REPEAT→INPUT transition.
  - When the increment would reach `MEM_DEPTH`, REPEAT goes to DONE instead of INPUT, with `clr_index` asserted and `cnt_count` not asserted.
  - `win` is registered to 1 on that edge and held until reset.
- **`SIMON_WIN_DETECT_EN` undefined:**
  - No round counter; `win` is tied to 0.
  - After `MEM_DEPTH` rounds the datapath count wraps and play continues, overwriting memory.

## Structure
- `simon_pkg` holds:
  - the state encoding (INIT, INPUT, PLAYBACK, REPEAT, DONE);
  - `LED_MODE_INPUT`=3'b001, `LED_MODE_PLAYBACK`=3'b010, `LED_MODE_REPEAT`=3'b100, `LED_MODE_DONE`=3'b111, `LED_MODE_INIT`=3'b000.
- Sub-module `simon_round_counter` (count/clear/full) is instantiated only under `SIMON_WIN_DETECT_EN`.
- The FSM state register and next-state/output logic stay in `simon_control`.

## Test plan
- **Reset and INIT:** hold `rst_n`=0, then release and apply one clk.
  - During reset, `set_level`/`clr_count`/`clr_index`=1 and `mode_leds`=000.
  - After the clk, `mode_leds`=001.
- **Illegal input:** in INPUT with `is_legal`=0, apply 3 clks.
  - `w_en`=0 throughout; state stays INPUT.
  - Then set `is_legal`=1: `w_en`=1 and `clr_index`=1; after the next clk, `mode_leds`=010.
- **Two-entry playback:** in PLAYBACK with `index_lt_count`=1, then 0.
  - First edge: `cnt_index`=1 and state stays.
  - Second edge: `clr_index`=1 and `mode_leds`=100.
- **Repeat success, then failure:**
  - REPEAT with `input_eq_pattern`=1 and `index_lt_count`=0: `cnt_count`=1, next `mode_leds`=001.
  - Later REPEAT with `input_eq_pattern`=0: `clr_index`=1, next `mode_leds`=111 and `read_Memory`=1.
- **DONE loop and async reset:**
  - In DONE, toggle `index_lt_count`: `cnt_index` and `clr_index` alternate accordingly.
  - Drive `rst_n`=0 between clk edges: `mode_leds`=000 immediately.
- **`SIMON_WIN_DETECT_EN` with `MEM_DEPTH`=4:** complete 4 rounds.
  - The 4th REPEAT success goes to DONE with `cnt_count`=0 and `win`=1.
  - With the macro undefined, the same stimulus goes to INPUT and `win`=0.
